// File: rtl/alu_issue_unit_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types
//   Shared types between the ALU reservation stations and the ALU issue unit.
//   rs_t    : one reservation-station entry (operands, tag, opcodes, valid)
//   sal_t   : one per-entry broadcast slot (rdy strobe + result data)
//   alu_ops : ALU operation codes
//   cmp_ops : comparator operation codes (only slt/sltu produce a value)
//   RS_IDX_W: width of a reservation-station index
// ---------------------------------------------------------------------------
package rv32i_types;

    localparam int RS_IDX_W = 3;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        cmp_beq  = 3'b000,
        cmp_bne  = 3'b001,
        cmp_slt  = 3'b010,
        cmp_sltu = 3'b011,
        cmp_blt  = 3'b100,
        cmp_bge  = 3'b101,
        cmp_bltu = 3'b110,
        cmp_bgeu = 3'b111
    } cmp_ops;

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [3:0]  tag;
        alu_ops      alu_opcode;
        cmp_ops      cmp_opcode;
        logic        valid;
    } rs_t;

    typedef struct packed {
        logic        rdy;
        logic [31:0] data;
    } sal_t;

endpackage

// File: rtl/alu_issue_unit_exec.sv
// ---------------------------------------------------------------------------
// alu_exec
//   Purely combinational ALU / comparator datapath used in the EX stage.
//   Ports:
//     alu_opcode in  alu_ops   ALU operation
//     cmp_opcode in  cmp_ops   comparator operation
//     acu        in  1         1 = comparator result, 0 = ALU result
//     a, b       in  32        operands (shift amount is b[4:0])
//     result     out 32        32-bit wrap-around result; compare gives 0/1
// ---------------------------------------------------------------------------
module alu_exec
    import rv32i_types::*;
(
    input  alu_ops      alu_opcode,
    input  cmp_ops      cmp_opcode,
    input  logic        acu,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic [31:0] alu_res;
    logic        cmp_bit;

    always_comb begin
        alu_res = '0;
        case (alu_opcode)
            alu_add: alu_res = a + b;
            alu_sub: alu_res = a - b;
            alu_sll: alu_res = a << b[4:0];
            alu_srl: alu_res = a >> b[4:0];
            alu_sra: alu_res = 32'($signed(a) >>> b[4:0]);
            alu_xor: alu_res = a ^ b;
            alu_or:  alu_res = a | b;
            alu_and: alu_res = a & b;
            default: alu_res = '0;
        endcase

        // Only the set-less-than flavours produce a value; branch codes give 0.
        cmp_bit = 1'b0;
        case (cmp_opcode)
            cmp_slt:  cmp_bit = ($signed(a) < $signed(b));
            cmp_sltu: cmp_bit = (a < b);
            default:  cmp_bit = 1'b0;
        endcase

        result = acu ? {31'b0, cmp_bit} : alu_res;
    end

endmodule

// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//   Picks one ready, not-in-flight reservation-station entry per cycle and
//   runs it through a two-stage EX/WB pipeline. A WB result is handed to the
//   ROB over cdb_*; on acceptance the owning RS entry is freed through
//   broadcast_bus and its in-flight bit is cleared.
//   Build option: ALU_ISSUE_RR_EN defined -> round-robin select starting at
//   rr_ptr; undefined -> fixed priority, lowest eligible index wins.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     flush          ROB mispredict flush (beats every other event)
//     rs_data        RS entries
//     acu_operation  per entry: 1 = comparator op, 0 = ALU op
//     rs_ready       per entry ready
//     cdb_ready      ROB accepts the WB result this cycle
//     broadcast_bus  per entry rdy strobe + result on ROB accept
//     cdb_valid/tag/data  WB result toward the ROB
//     issue_stall    WB is held by the ROB
// ---------------------------------------------------------------------------
module alu_issue_unit
    import rv32i_types::*;
#(
    parameter int RS_SIZE = 8,
    parameter int IDX_W   = RS_IDX_W
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  rs_t  [RS_SIZE-1:0]   rs_data,
    input  logic [RS_SIZE-1:0]   acu_operation,
    input  logic [RS_SIZE-1:0]   rs_ready,
    input  logic                 cdb_ready,
    output sal_t [RS_SIZE-1:0]   broadcast_bus,
    output logic                 cdb_valid,
    output logic [3:0]           cdb_tag,
    output logic [31:0]          cdb_data,
    output logic                 issue_stall
);

    // Control state
    logic               ex_valid_q, ex_valid_d;
    logic               wb_valid_q, wb_valid_d;
    logic [RS_SIZE-1:0] inflight_q, inflight_d;
`ifdef ALU_ISSUE_RR_EN
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   cand;
`endif

    // EX stage data
    logic [31:0]        ex_r1_q, ex_r1_d;
    logic [31:0]        ex_r2_q, ex_r2_d;
    alu_ops             ex_alu_op_q, ex_alu_op_d;
    cmp_ops             ex_cmp_op_q, ex_cmp_op_d;
    logic               ex_acu_q, ex_acu_d;
    logic [3:0]         ex_tag_q, ex_tag_d;
    logic [IDX_W-1:0]   ex_idx_q, ex_idx_d;

    // WB stage data
    logic [31:0]        wb_data_q, wb_data_d;
    logic [3:0]         wb_tag_q, wb_tag_d;
    logic [IDX_W-1:0]   wb_idx_q, wb_idx_d;

    logic [RS_SIZE-1:0] eligible;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               issue;
    logic               hold;
    logic               accept;
    logic [31:0]        ex_result;
    logic [RS_SIZE-1:0] unused_rs_valid;

    // The valid bit is already folded into rs_ready by the RS.
    always_comb begin
        unused_rs_valid = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            unused_rs_valid[i] = rs_data[i].valid;
        end
    end

    // A flush or reset cycle never presents a result, so nothing can be
    // accepted or broadcast while the pipeline is being cleared.
    assign cdb_valid   = wb_valid_q && !rst && !flush;
    assign accept      = cdb_valid && cdb_ready;
    assign hold        = cdb_valid && !cdb_ready;
    assign issue_stall = hold;
    assign cdb_tag     = cdb_valid ? wb_tag_q  : 4'd0;
    assign cdb_data    = cdb_valid ? wb_data_q : 32'd0;

    // Select: an entry still marked in flight during its own accept cycle is
    // not eligible, so a just-broadcast entry cannot re-issue the same cycle.
    always_comb begin
        eligible  = rs_ready & ~inflight_q;
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef ALU_ISSUE_RR_EN
        cand      = '0;
        for (int k = 0; k < RS_SIZE; k++) begin
            cand = rr_ptr_q + IDX_W'(k);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
`else
        for (int k = RS_SIZE - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k);
            end
        end
`endif
    end

    assign issue = sel_found && !hold;

    // ---- EX stage ----
    alu_exec u_exec (
        .alu_opcode (ex_alu_op_q),
        .cmp_opcode (ex_cmp_op_q),
        .acu        (ex_acu_q),
        .a          (ex_r1_q),
        .b          (ex_r2_q),
        .result     (ex_result)
    );

    always_comb begin
        ex_valid_d  = issue ? 1'b1 : (hold ? ex_valid_q : 1'b0);
        wb_valid_d  = hold ? 1'b1 : ex_valid_q;

        inflight_d  = inflight_q;
        if (accept) begin
            inflight_d[wb_idx_q] = 1'b0;
        end
        if (issue) begin
            inflight_d[sel_idx] = 1'b1;
        end

`ifdef ALU_ISSUE_RR_EN
        rr_ptr_d    = issue ? (sel_idx + IDX_W'(1)) : rr_ptr_q;
`endif

        ex_r1_d     = ex_r1_q;
        ex_r2_d     = ex_r2_q;
        ex_alu_op_d = ex_alu_op_q;
        ex_cmp_op_d = ex_cmp_op_q;
        ex_acu_d    = ex_acu_q;
        ex_tag_d    = ex_tag_q;
        ex_idx_d    = ex_idx_q;
        if (issue) begin
            ex_r1_d     = rs_data[sel_idx].r1;
            ex_r2_d     = rs_data[sel_idx].r2;
            ex_alu_op_d = rs_data[sel_idx].alu_opcode;
            ex_cmp_op_d = rs_data[sel_idx].cmp_opcode;
            ex_acu_d    = acu_operation[sel_idx];
            ex_tag_d    = rs_data[sel_idx].tag;
            ex_idx_d    = sel_idx;
        end

        wb_data_d   = hold ? wb_data_q : ex_result;
        wb_tag_d    = hold ? wb_tag_q  : ex_tag_q;
        wb_idx_d    = hold ? wb_idx_q  : ex_idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            inflight_q <= '0;
`ifdef ALU_ISSUE_RR_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            ex_valid_q <= ex_valid_d;
            wb_valid_q <= wb_valid_d;
            inflight_q <= inflight_d;
`ifdef ALU_ISSUE_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        ex_r1_q     <= ex_r1_d;
        ex_r2_q     <= ex_r2_d;
        ex_alu_op_q <= ex_alu_op_d;
        ex_cmp_op_q <= ex_cmp_op_d;
        ex_acu_q    <= ex_acu_d;
        ex_tag_q    <= ex_tag_d;
        ex_idx_q    <= ex_idx_d;
        wb_data_q   <= wb_data_d;
        wb_tag_q    <= wb_tag_d;
        wb_idx_q    <= wb_idx_d;
    end

    // ---- WB stage ----
    always_comb begin
        broadcast_bus = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (accept && (wb_idx_q == IDX_W'(i))) begin
                broadcast_bus[i].rdy  = 1'b1;
                broadcast_bus[i].data = wb_data_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;
    import rv32i_types::*;

    localparam int RS_SIZE = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    rs_t  [RS_SIZE-1:0]   rs_data;
    logic [RS_SIZE-1:0]   acu_operation;
    logic [RS_SIZE-1:0]   rs_ready;
    logic                 cdb_ready;
    sal_t [RS_SIZE-1:0]   broadcast_bus;
    logic                 cdb_valid;
    logic [3:0]           cdb_tag;
    logic [31:0]          cdb_data;
    logic                 issue_stall;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ord [9];

    always #5 clk = ~clk;

    alu_issue_unit #(.RS_SIZE(RS_SIZE), .IDX_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .rs_data       (rs_data),
        .acu_operation (acu_operation),
        .rs_ready      (rs_ready),
        .cdb_ready     (cdb_ready),
        .broadcast_bus (broadcast_bus),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .issue_stall   (issue_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rdy_vec();
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < RS_SIZE; i++) v[i] = broadcast_bus[i].rdy;
        return v;
    endfunction

    function automatic logic [31:0] bcast_data(input logic [7:0] v);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < RS_SIZE; i++) if (v[i]) d = broadcast_bus[i].data;
        return d;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_entry(input int i, input logic [31:0] a, input logic [31:0] b,
                             input alu_ops op, input cmp_ops cop, input logic acu,
                             input logic [3:0] tag);
        rs_data[i].r1         = a;
        rs_data[i].r2         = b;
        rs_data[i].tag        = tag;
        rs_data[i].alu_opcode = op;
        rs_data[i].cmp_opcode = cop;
        rs_data[i].valid      = 1'b1;
        acu_operation[i]      = acu;
    endtask

    task automatic run_one(input string tag, input int i, input logic [31:0] a,
                           input logic [31:0] b, input alu_ops op, input cmp_ops cop,
                           input logic acu, input logic [31:0] exp);
        set_entry(i, a, b, op, cop, acu, 4'(i + 8));
        rs_ready  = 8'(1 << i);
        cdb_ready = 1'b1;
        tick();
        rs_ready = '0;
        tick();
        check({tag, "_vld"}, 32'(cdb_valid), 32'd1);
        check(tag, cdb_data, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got no summary, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        int         nb;
        int         idx;

`ifdef ALU_ISSUE_RR_EN
        exp_ord = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
`else
        exp_ord = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
`endif
        rst           = 1'b1;
        flush         = 1'b0;
        rs_data       = '0;
        acu_operation = '0;
        rs_ready      = '0;
        cdb_ready     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", 32'(cdb_valid), 32'd0);
        check("rst_tag",   32'(cdb_tag),   32'd0);
        check("rst_data",  cdb_data,       32'd0);
        check("rst_bcast", 32'(rdy_vec()), 32'd0);
        check("rst_stall", 32'(issue_stall), 32'd0);

        // Test 1/2: single add on entry 2, ready held for three sampled edges
        set_entry(2, 32'd5, 32'd7, alu_add, cmp_beq, 1'b0, 4'd3);
        rs_ready  = 8'h04;
        cdb_ready = 1'b1;
        tick();
        check("t1_lat1", 32'(cdb_valid), 32'd0);
        tick();
        check("t1_valid", 32'(cdb_valid), 32'd1);
        check("t1_tag",   32'(cdb_tag),   32'd3);
        check("t1_data",  cdb_data,       32'd12);
        check("t1_bcast", 32'(rdy_vec()), 32'h04);
        check("t1_bdata", bcast_data(rdy_vec()), 32'd12);
        tick();
        rs_ready = '0;
        for (int c = 0; c < 3; c++) begin
            check("t2_noreissue", 32'(cdb_valid), 32'd0);
            check("t2_nobcast",   32'(rdy_vec()), 32'd0);
            tick();
        end

        // Test 3: back-pressure with EX and WB both full
        set_entry(0, 32'd1,  32'd1, alu_add, cmp_beq, 1'b0, 4'd5);
        set_entry(1, 32'd10, 32'd3, alu_sub, cmp_beq, 1'b0, 4'd6);
        rs_ready  = 8'h03;
        cdb_ready = 1'b0;
        tick();
        tick();
        rs_ready = '0;
        for (int c = 0; c < 3; c++) begin
            check("t3_hold_vld",   32'(cdb_valid),   32'd1);
            check("t3_hold_tag",   32'(cdb_tag),     32'd5);
            check("t3_hold_data",  cdb_data,         32'd2);
            check("t3_hold_stall", 32'(issue_stall), 32'd1);
            check("t3_hold_bcast", 32'(rdy_vec()),   32'd0);
            if (c < 2) tick();
        end
        cdb_ready = 1'b1;
        #1;
        check("t3_rel_bcast0", 32'(rdy_vec()),   32'h01);
        check("t3_rel_stall",  32'(issue_stall), 32'd0);
        tick();
        check("t3_rel_tag1",   32'(cdb_tag),     32'd6);
        check("t3_rel_data1",  cdb_data,         32'd7);
        check("t3_rel_bcast1", 32'(rdy_vec()),   32'h02);
        tick();
        check("t3_drained",    32'(cdb_valid),   32'd0);

        // Test 4: arithmetic corners
        run_one("t4_slt",   3, 32'hFFFF_FFFF, 32'd1, alu_add, cmp_slt,  1'b1, 32'd1);
        run_one("t4_sltu",  3, 32'hFFFF_FFFF, 32'd1, alu_add, cmp_sltu, 1'b1, 32'd0);
        run_one("t4_cmpot", 3, 32'd1, 32'd1, alu_add, cmp_beq, 1'b1, 32'd0);
        run_one("t4_addwr", 3, 32'hFFFF_FFFF, 32'd1, alu_add, cmp_beq, 1'b0, 32'd0);
        run_one("t4_sra",   3, 32'h8000_0000, 32'd4, alu_sra, cmp_beq, 1'b0, 32'hF800_0000);
        run_one("t4_srl",   3, 32'h8000_0000, 32'd4, alu_srl, cmp_beq, 1'b0, 32'h0800_0000);
        run_one("t4_sll33", 3, 32'd1, 32'd33, alu_sll, cmp_beq, 1'b0, 32'd2);
        run_one("t4_sub",   3, 32'd5, 32'd7, alu_sub, cmp_beq, 1'b0, 32'hFFFF_FFFE);
        run_one("t4_and",   3, 32'h0000_F0F0, 32'h0000_FF00, alu_and, cmp_beq, 1'b0, 32'h0000_F000);
        run_one("t4_or",    3, 32'h0000_F0F0, 32'h0000_FF00, alu_or,  cmp_beq, 1'b0, 32'h0000_FFF0);

        // Test 5: flush with EX and WB full
        set_entry(4, 32'd20,  32'd22,  alu_add, cmp_beq, 1'b0, 4'd7);
        set_entry(5, 32'hF0,  32'h0F,  alu_xor, cmp_beq, 1'b0, 4'd8);
        rs_ready  = 8'h30;
        cdb_ready = 1'b0;
        tick();
        tick();
        check("t5_pre_tag", 32'(cdb_tag), 32'd7);
        flush    = 1'b1;
        rs_ready = '0;
        tick();
        flush = 1'b0;
        check("t5_vld",   32'(cdb_valid),   32'd0);
        check("t5_bcast", 32'(rdy_vec()),   32'd0);
        check("t5_stall", 32'(issue_stall), 32'd0);
        check("t5_data",  cdb_data,         32'd0);
        cdb_ready = 1'b1;
        rs_ready  = 8'h30;
        tick();
        check("t5_lat", 32'(cdb_valid), 32'd0);
        tick();
        rs_ready = '0;
        check("t5_re_tag4",   32'(cdb_tag),   32'd7);
        check("t5_re_data4",  cdb_data,       32'd42);
        check("t5_re_bcast4", 32'(rdy_vec()), 32'h10);
        tick();
        check("t5_re_tag5",   32'(cdb_tag),   32'd8);
        check("t5_re_data5",  cdb_data,       32'hFF);
        check("t5_re_bcast5", 32'(rdy_vec()), 32'h20);
        tick();
        check("t5_drained",   32'(cdb_valid), 32'd0);

        // Test 6: all entries ready, no back-pressure; observe issue order
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            set_entry(i, 32'(i), 32'd0, alu_add, cmp_beq, 1'b0, 4'(i));
        end
        cdb_ready = 1'b1;
        rs_ready  = 8'hFF;
        nb = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 8) rs_ready = '0;
            v = rdy_vec();
            if (v != 8'd0) begin
                check("t6_onehot", 32'($countones(v)), 32'd1);
                idx = 0;
                for (int i = 0; i < RS_SIZE; i++) if (v[i]) idx = i;
                if (nb < 9) begin
                    check($sformatf("t6_order%0d", nb), 32'(idx), 32'(exp_ord[nb]));
                    check($sformatf("t6_data%0d", nb), bcast_data(v), 32'(exp_ord[nb]));
                end
                nb++;
            end
        end
        check("t6_count", 32'(nb), 32'd9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
